// File: rtl/divider8bit.sv
// divider8bit -- sequential unsigned restoring divider, one quotient bit
// per clock. It shares the S/F start/finish handshake with the
// repeated-addition multiplier.
//
// Ports:
//   CLK   clock, rising edge
//   RESET asynchronous, active-high reset
//   S     start request, sampled only in IDLE
//   IN1   dividend (unsigned, WIDTH bits)
//   IN2   divisor  (unsigned, WIDTH bits)
//   F     one-cycle finish pulse, high while results have just updated
//   Q     quotient, registered, held until the next completion
//   R     remainder, registered, held until the next completion
//   DZ    divide-by-zero flag of the last completed operation
//   BUSY  high from the accept edge until the completion edge
//
// Timing: accept edge t0, WIDTH DIVIDE edges, one DONE edge. F is then
// high for one cycle. A zero divisor skips DIVIDE, so F follows t1.
module divider8bit #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             S,
  input  logic [WIDTH-1:0] IN1,
  input  logic [WIDTH-1:0] IN2,
  output logic             F,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             DZ,
  output logic             BUSY
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a;        // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] b;        // captured divisor
  logic [WIDTH:0]   p;        // partial remainder
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   sh;
  logic             ge;
  logic             last;

  // The partial remainder is always below the divisor, so its top bit
  // never feeds the next shift.
  logic unused_p_msb;
  assign unused_p_msb = p[WIDTH];

  assign sh   = {p[WIDTH-1:0], a[WIDTH-1]};
  assign ge   = (sh >= {1'b0, b});
  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (S) state_nxt = (IN2 != '0) ? DIVIDE : DONE;
      DIVIDE:  if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      a    <= '0;
      b    <= '0;
      p    <= '0;
      cnt  <= '0;
      F    <= 1'b0;
      Q    <= '0;
      R    <= '0;
      DZ   <= 1'b0;
      BUSY <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          F <= 1'b0;
          if (S) begin
            a    <= IN1;
            b    <= IN2;
            p    <= '0;
            cnt  <= '0;
            BUSY <= 1'b1;
          end
        end
        DIVIDE: begin
          p   <= ge ? (sh - {1'b0, b}) : sh;
          a   <= {a[WIDTH-2:0], ge};
          cnt <= cnt + 1'b1;
        end
        DONE: begin
          if (b != '0) begin
            Q  <= a;
            R  <= p[WIDTH-1:0];
            DZ <= 1'b0;
          end else begin
            // DIVIDE was skipped, so a still holds the captured dividend.
            Q  <= '1;
            R  <= a;
            DZ <= 1'b1;
          end
          F    <= 1'b1;
          BUSY <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/divider8bit.md
Name: divider8bit

Overview:
- Sequential unsigned integer divider. It is the inverse of the team's repeated-addition multiplier.
- It uses restoring shift-subtract division and produces one quotient bit per clock.
- It sits beside the multiplier in the arithmetic datapath and uses the same start/finish handshake (S in, F out).
- It reports divide-by-zero instead of hanging.

Parameters:
- WIDTH, 8, bit width of the dividend, divisor, quotient and remainder (WIDTH >= 2).

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  reset, asynchronous, active-high.
- S  input  1  start request; sampled only in IDLE.
- IN1  input  WIDTH  dividend (unsigned).
- IN2  input  WIDTH  divisor (unsigned).
- F  output  1  finish pulse; high for exactly one cycle when results update.
- Q  output  WIDTH  quotient; registered, held until the next completion.
- R  output  WIDTH  remainder; registered, held until the next completion.
- DZ  output  1  divide-by-zero flag for the last completed operation; held with Q/R.
- BUSY  output  1  high from the accept edge until the completion edge.

Behaviour:
- Reset (async, any state): state=IDLE, F=0, Q=0, R=0, DZ=0, BUSY=0; internal A, B, P and cnt cleared. An operation in flight is abandoned with no F pulse.
- State machine: IDLE, DIVIDE, DONE.
- IDLE:
  - F<=0 on every edge.
  - If S=1 at edge t0: capture A<=IN1, B<=IN2, P<=0, cnt<=0, BUSY<=1.
  - Next state is DIVIDE if IN2!=0, DONE if IN2==0.
  - IN1/IN2 need not be held stable after t0.
- DIVIDE, per edge:
  - sh = {P[WIDTH-1:0], A[WIDTH-1]}; P is WIDTH+1 bits.
  - If sh >= {0,B}: P<=sh-B, A<={A[WIDTH-2:0],1}; else P<=sh, A<={A[WIDTH-2:0],0}.
  - cnt<=cnt+1.
  - When cnt==WIDTH-1 on this edge, next state is DONE. Exactly WIDTH DIVIDE edges (t1..tWIDTH).
- DONE, one edge, then next state is IDLE:
  - If B!=0: Q<=A, R<=P[WIDTH-1:0], DZ<=0.
  - If B==0: Q<=all ones, R<=captured dividend, DZ<=1. The captured dividend is held in A, which is untouched because DIVIDE is skipped.
  - F<=1, BUSY<=0.
- Latency:
  - Normal: F high in the cycle after edge t(WIDTH+1), i.e. 9 edges after accept for WIDTH=8.
  - Divide-by-zero: F high after edge t1.
- F is cleared at the following edge (IDLE). If S=1 at that same edge, a new operation is accepted, which gives back-to-back throughput of one result per WIDTH+2 cycles.
- S is ignored while BUSY=1 (DIVIDE/DONE). A held-high S restarts only once back in IDLE.
- Q/R/DZ change only on the DONE edge or on reset; they stay stable through subsequent IDLE and busy periods.
- Arithmetic invariant for B!=0: IN1 == Q*IN2 + R, and R < IN2.
- Combinational outputs: none; all outputs are registers.

Test Plan:
- Reset, then IN1=100, IN2=7, S pulse at t0 -> BUSY=1 from t0; F=1 for one cycle after edge t9; Q=14, R=2, DZ=0, BUSY=0 after t9.
- Edge values, each run separately: 255/1 -> Q=255, R=0; 5/9 -> Q=0, R=5; 0/3 -> Q=0, R=0; 255/255 -> Q=1, R=0; 254/255 -> Q=0, R=254. Each gives F after 9 edges.
- IN1=37, IN2=0, S pulse -> F after edge t1; Q=255, R=37, DZ=1. Then 10/3 -> DZ=0, Q=3, R=1.
- S held high continuously with IN1=200, IN2=13 -> results Q=15, R=5. Operation accepted every 10 edges; F one-cycle pulses 10 edges apart. Changing IN1/IN2 mid-operation does not affect the result.
- Start 100/7, assert RESET asynchronously mid-cycle after edge t4 -> immediately Q=0, R=0, F=0, BUSY=0. No F pulse afterwards; a new 50/6 completes with Q=8, R=2.
- Random sweep, WIDTH=8, 1000 operand pairs with divisor nonzero -> Q*IN2+R==IN1 and R<IN2 for every F pulse; Q/R/DZ stable between F pulses.
